// File: rtl/ot_wr_arb.sv
//------------------------------------------------------------------------------
// ot_wr_arb : round-robin gather of 4 single-entry word holders into a buffer
// Rev 1.0   : initial release
//------------------------------------------------------------------------------
`default_nettype none

module ot_wr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic [15:0]               cfg_word_num,
  input  logic [ADDR_W-1:0]         cfg_base_addr,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic                      buf_wen,
  output logic [ADDR_W-1:0]         buf_addr,
  output logic [DATA_W-1:0]         buf_wdata,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_REQ-1:0]        ovf_err
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         word_num;
  logic [15:0]         wcnt;
  logic [ADDR_W-1:0]   base;
  logic [NUM_REQ-1:0]  pending;
  logic [DATA_W-1:0]   hold [NUM_REQ];
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       grant_idx;
  logic [GW-1:0]       idx;
  logic                grant_vld;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                quota_left;

  assign quota_left = (wcnt != word_num);

  // Round-robin search starting one past the last grant; k == NUM_REQ wraps to last_grant itself.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    grant_oh  = '0;
    idx       = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last_grant + GW'(k);
      if (!grant_vld && pending[idx] && (state == RUN) && quota_left) begin
        grant_vld     = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = RUN;
      RUN:     if (!quota_left) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word_num   <= '0;
      wcnt       <= '0;
      base       <= '0;
      pending    <= '0;
      last_grant <= '1;
      buf_wen    <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      ovf_err    <= '0;
    end else begin
      state   <= state_nxt;
      buf_wen <= 1'b0;
      if ((state == IDLE) && cfg_start) begin
        word_num <= cfg_word_num;
        base     <= cfg_base_addr;
        wcnt     <= '0;
        ovf_err  <= '0;
      end
      if (grant_vld) begin
        buf_wen    <= 1'b1;
        buf_addr   <= base + ADDR_W'(wcnt);
        buf_wdata  <= hold[grant_idx];
        wcnt       <= wcnt + 16'd1;
        last_grant <= grant_idx;
      end
      if (state == RUN) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (in_valid[i] && (!pending[i] || grant_oh[i])) begin
            pending[i] <= 1'b1;
          end else if (in_valid[i]) begin
            ovf_err[i] <= 1'b1;
          end else if (grant_oh[i]) begin
            pending[i] <= 1'b0;
          end
        end
      end
      // Words still waiting when the quota is met are discarded here.
      if (state_nxt == DONE) pending <= '0;
    end
  end

  // Holding data needs no reset: it is only read when its pending bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state == RUN) && in_valid[i] && (!pending[i] || grant_oh[i]))
        hold[i] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_ot_wr_arb.sv
//------------------------------------------------------------------------------
// tb_ot_wr_arb : self-checking bench for ot_wr_arb
// Rev 1.0      : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ot_wr_arb;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_start;
  logic [15:0]  cfg_word_num;
  logic [15:0]  cfg_base_addr;
  logic [3:0]   in_valid;
  logic [255:0] in_data;
  logic         buf_wen;
  logic [15:0]  buf_addr;
  logic [63:0]  buf_wdata;
  logic         busy;
  logic         done;
  logic [3:0]   ovf_err;

  ot_wr_arb #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_word_num(cfg_word_num),
    .cfg_base_addr(cfg_base_addr), .in_valid(in_valid), .in_data(in_data),
    .buf_wen(buf_wen), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .busy(busy), .done(done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] base;
    logic [15:0] num;
    logic [3:0]  mask;
    int          nw;
    logic [7:0]  ord;
    int          done_at;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] word(input int e, input int r);
    return {16'hC0DE, 8'(e), 8'(r), 32'h1357_9BDF ^ 32'(e * 16 + r)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [63:0] d, input int c);
    exp_t x;
    x.addr = a;
    x.data = d;
    x.cyc  = c;
    sb.push_back(x);
  endtask

  // Every observed write is matched against the oldest expected one.
  always @(posedge clk) begin
    #2;
    if (buf_wen === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", buf_addr, buf_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", buf_addr, e.addr);
        chk("wr_data", buf_wdata, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_done(input string nm, input int exp_cyc);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_done_cycle"}, cyc, exp_cyc);
    chk({nm, "_all_written"}, sb.size(), 0);
  endtask

  task automatic start_job(input logic [15:0] num, input logic [15:0] base);
    cfg_word_num  = num;
    cfg_base_addr = base;
    cfg_start     = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_vec(input vec_t v, input int e);
    int m;
    start_job(v.num, v.base);
    m = cyc;
    in_valid = v.mask;
    for (int r = 0; r < 4; r++) in_data[r*64 +: 64] = word(e, r);
    for (int k = 0; k < v.nw; k++)
      push(v.base + 16'(k), word(e, int'(v.ord[2*k +: 2])), m + 2 + k);
    tick();
    in_valid = '0;
    wait_done($sformatf("vec%0d", e), m + v.done_at);
    chk("vec_ovf", ovf_err, 0);
    chk("vec_busy_in_done", busy, 0);
    tick();
    chk("vec_idle_busy", busy, 0);
    chk("vec_idle_done", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int m;
    int c3;
    int n;

    vt[0] = '{16'h0100, 16'd4, 4'b1111, 4, 8'hE4, 6};
    vt[1] = '{16'hFFFE, 16'd4, 4'b1111, 4, 8'hE4, 6};
    vt[2] = '{16'h0200, 16'd0, 4'b1111, 0, 8'h00, 1};
    vt[3] = '{16'h0300, 16'd2, 4'b1010, 2, 8'h0D, 4};
    vt[4] = '{16'h0400, 16'd3, 4'b0111, 3, 8'h24, 5};
    vt[5] = '{16'h0500, 16'd2, 4'b1101, 2, 8'h03, 4};
    vt[6] = '{16'h0600, 16'd1, 4'b0110, 1, 8'h01, 3};
    vt[7] = '{16'h0700, 16'd3, 4'b1011, 3, 8'h13, 5};

    reset         = 1'b1;
    cfg_start     = 1'b0;
    cfg_word_num  = '0;
    cfg_base_addr = '0;
    in_valid      = '0;
    in_data       = '0;
    tick();
    tick();
    chk("rst_buf_wen", buf_wen, 0);
    chk("rst_buf_addr", buf_addr, 0);
    chk("rst_buf_wdata", buf_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf_err, 0);
    reset = 1'b0;
    tick();

    for (int e = 0; e < 8; e++) run_vec(vt[e], e);

    // Single requester, words 4 cycles apart; a cfg_start mid-run is ignored.
    start_job(16'd3, 16'h0100);
    c3 = cyc;
    for (int w = 0; w < 3; w++) begin
      in_valid = 4'b0100;
      in_data[128 +: 64] = word(20, w);
      push(16'h0100 + 16'(w), word(20, w), cyc + 2);
      c3 = cyc;
      tick();
      in_valid = '0;
      if (w < 2) begin
        if (w == 1) begin
          cfg_start     = 1'b1;
          cfg_word_num  = 16'd9;
          cfg_base_addr = 16'h7777;
        end
        tick();
        cfg_start = 1'b0;
        tick();
        tick();
      end
    end
    wait_done("single", c3 + 3);
    chk("single_ovf", ovf_err, 0);
    tick();

    // Overflow: both 0 and 1 strobe every cycle while both stay pending.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_job(16'd4, 16'h0800);
    n = cyc;
    push(16'h0800, word(30, 0), n + 2);
    push(16'h0801, word(30, 1), n + 3);
    push(16'h0802, word(31, 0), n + 4);
    push(16'h0803, word(32, 1), n + 5);
    for (int j = 0; j < 3; j++) begin
      in_valid = 4'b0011;
      in_data[0 +: 64]  = word(30 + j, 0);
      in_data[64 +: 64] = word(30 + j, 1);
      tick();
      if (j == 1) chk("ovf_req1_first", ovf_err, 4'b0010);
    end
    in_valid = '0;
    chk("ovf_both", ovf_err, 4'b0011);
    wait_done("ovf", n + 6);
    chk("ovf_at_done", ovf_err, 4'b0011);
    tick();
    chk("ovf_sticky_idle", ovf_err, 4'b0011);

    // Reset after 2 of 5 writes; last grant was requester 1.
    start_job(16'd5, 16'h0900);
    m = cyc;
    chk("ovf_cleared_by_start", ovf_err, 0);
    in_valid = 4'b1111;
    for (int r = 0; r < 4; r++) in_data[r*64 +: 64] = word(40, r);
    push(16'h0900, word(40, 2), m + 2);
    push(16'h0901, word(40, 3), m + 3);
    push(16'h0902, word(40, 0), m + 4);
    push(16'h0903, word(40, 1), m + 5);
    tick();
    in_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_writes_left", sb.size(), 2);
    sb.delete();
    chk("abort_buf_wen", buf_wen, 0);
    chk("abort_buf_addr", buf_addr, 0);
    chk("abort_buf_wdata", buf_wdata, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf", ovf_err, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end

    start_job(16'd1, 16'h0A00);
    m = cyc;
    in_valid = 4'b1111;
    for (int r = 0; r < 4; r++) in_data[r*64 +: 64] = word(41, r);
    push(16'h0A00, word(41, 0), m + 2);
    tick();
    in_valid = '0;
    wait_done("after_abort", m + 3);
    tick();
    tick();
    chk("final_no_stray_writes", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
